// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage predictor: prediction modes,
// the PC increment and saturating counter helpers.
package cpu_pkg;

  // Sequential fetch advances by one halfword-aligned instruction.
  localparam int unsigned PC_STEP = 2;

  // Widest direction counter the helpers support.
  localparam int unsigned CTR_MAX_W = 4;

  typedef enum logic [1:0] {
    PM_STATIC    = 2'd0,
    PM_BIMODAL   = 2'd1,
    PM_HIT_TAKEN = 2'd2
  } pred_mode_e;

  // Increment a counter of 'width' bits, holding at its all-ones value.
  function automatic logic [CTR_MAX_W-1:0] ctr_inc_sat(
    input logic [CTR_MAX_W-1:0] val,
    input int unsigned          width
  );
    logic [CTR_MAX_W-1:0] maxVal;
    maxVal = CTR_MAX_W'((1 << width) - 1);
    return (val >= maxVal) ? maxVal : val + CTR_MAX_W'(1);
  endfunction

  // Decrement a counter of 'width' bits, holding at zero; an out-of-range
  // input is pulled back to the top of the legal range.
  function automatic logic [CTR_MAX_W-1:0] ctr_dec_sat(
    input logic [CTR_MAX_W-1:0] val,
    input int unsigned          width
  );
    logic [CTR_MAX_W-1:0] maxVal;
    maxVal = CTR_MAX_W'((1 << width) - 1);
    if (val > maxVal) begin
      return maxVal;
    end
    return (val == '0) ? '0 : val - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/bimodal_btb_if.sv
// Fetch lookup, execute update and performance counter signals of the
// branch target buffer. The master drives requests, the slave predicts.
interface bimodal_btb_if #(
  parameter int PC_W   = 16,
  parameter int PERF_W = 16
);

  logic              lookup_valid;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;

  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_is_branch;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic              upd_mispredict;

  logic [PERF_W-1:0] perf_lookups;
  logic [PERF_W-1:0] perf_mispredicts;

  modport master (
    output lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target,
    input  perf_lookups, perf_mispredicts
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target,
    output perf_lookups, perf_mispredicts
  );

endinterface

// File: rtl/btb_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module btb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step once per enabled cycle until all-ones is reached.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared while reset is low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bimodal_btb.sv
// Tag-checked branch target buffer with a per-entry saturating direction
// counter. Fetch gets a zero-latency prediction; execute trains the table.
module bimodal_btb
  import cpu_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int INDEX_W   = 4,
  parameter int CTR_W     = 2,
  parameter int PRED_MODE = 1,
  parameter int BYPASS    = 1,
  parameter int PERF_W    = 16
) (
  input logic          clk,
  input logic          reset,
  bimodal_btb_if.slave btb
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = PC_W - INDEX_W - 1;

  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam pred_mode_e       MODE        = pred_mode_e'(PRED_MODE);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [CTR_W-1:0] ctr;
  } entry_t;

  entry_t table_q [ENTRIES];
  entry_t entry_d;

  logic [PC_W-2:0]    lkHalf;
  logic [INDEX_W-1:0] lkIdx;
  logic [TAG_W-1:0]   lkTag;
  logic [PC_W-2:0]    updHalf;
  logic [INDEX_W-1:0] updIdx;
  logic [TAG_W-1:0]   updTag;
  logic               updHit;
  logic               updWrite;
  entry_t             lkEntry;
  logic               predHit;
  logic               predTaken;
  logic [PC_W-1:0]    predTarget;

  // Bit 0 of a PC is always zero, so fields are cut from the halfword address.
  assign lkHalf  = (PC_W-1)'(btb.lookup_pc >> 1);
  assign lkIdx   = lkHalf[INDEX_W-1:0];
  assign lkTag   = lkHalf[PC_W-2:INDEX_W];
  assign updHalf = (PC_W-1)'(btb.upd_pc >> 1);
  assign updIdx  = updHalf[INDEX_W-1:0];
  assign updTag  = updHalf[PC_W-2:INDEX_W];
  assign updHit  = table_q[updIdx].valid && (table_q[updIdx].tag == updTag);

  // Build the new contents of the slot addressed by the resolving instruction.
  always_comb begin
    updWrite = 1'b0;
    entry_d  = table_q[updIdx];
    if (reset && btb.upd_valid) begin
      if (btb.upd_is_branch) begin
        updWrite       = 1'b1;
        entry_d.target = btb.upd_target;
        if (updHit) begin
          if (btb.upd_taken) begin
            entry_d.ctr = CTR_W'(ctr_inc_sat(CTR_MAX_W'(table_q[updIdx].ctr), CTR_W));
          end else begin
            entry_d.ctr = CTR_W'(ctr_dec_sat(CTR_MAX_W'(table_q[updIdx].ctr), CTR_W));
          end
        end else begin
          entry_d.valid = 1'b1;
          entry_d.tag   = updTag;
          entry_d.ctr   = btb.upd_taken ? CTR_WEAK_T : CTR_WEAK_NT;
        end
      end else if (updHit) begin
        updWrite      = 1'b1;
        entry_d.valid = 1'b0;
      end
    end
  end

  // Table storage; reset forgets every entry and re-arms counters weak-not-taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
        table_q[i].ctr   <= CTR_WEAK_NT;
      end
    end else if (updWrite) begin
      table_q[updIdx] <= entry_d;
    end
  end

  // Prediction for the fetch PC, optionally seeing a same-slot update early.
  always_comb begin
    lkEntry = table_q[lkIdx];
    if ((BYPASS != 0) && updWrite && (updIdx == lkIdx)) begin
      lkEntry = entry_d;
    end
    predHit = reset && btb.lookup_valid && lkEntry.valid && (lkEntry.tag == lkTag);
    case (MODE)
      PM_STATIC:    predTaken = 1'b0;
      PM_BIMODAL:   predTaken = predHit && lkEntry.ctr[CTR_W-1];
      PM_HIT_TAKEN: predTaken = predHit;
      default:      predTaken = 1'b0;
    endcase
    predTarget = predTaken ? lkEntry.target : btb.lookup_pc + PC_W'(PC_STEP);
  end

  assign btb.pred_hit    = predHit;
  assign btb.pred_taken  = predTaken;
  assign btb.pred_target = predTarget;

  btb_sat_counter #(
    .W (PERF_W)
  ) uPerfLookups (
    .clk     (clk),
    .reset   (reset),
    .en_i    (btb.lookup_valid),
    .count_o (btb.perf_lookups)
  );

  btb_sat_counter #(
    .W (PERF_W)
  ) uPerfMispredicts (
    .clk     (clk),
    .reset   (reset),
    .en_i    (btb.upd_valid && btb.upd_mispredict),
    .count_o (btb.perf_mispredicts)
  );

endmodule

// File: tb/tb_bimodal_btb.sv
// Bench for bimodal_btb: two configurations share one stimulus stream and
// are compared every cycle against a table-of-entries reference model.
module tb_bimodal_btb;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  bimodal_btb_if #(.PC_W(16), .PERF_W(4))  ifA ();
  bimodal_btb_if #(.PC_W(16), .PERF_W(16)) ifB ();

  bimodal_btb #(
    .PC_W(16), .INDEX_W(4), .CTR_W(2), .PRED_MODE(1), .BYPASS(1), .PERF_W(4)
  ) dutA (
    .clk   (clk),
    .reset (reset),
    .btb   (ifA)
  );

  bimodal_btb #(
    .PC_W(16), .INDEX_W(4), .CTR_W(2), .PRED_MODE(2), .BYPASS(0), .PERF_W(16)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .btb   (ifB)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int tag;
    int target;
    int ctr;
  } mEntry_t;

  mEntry_t mTab [2][16];
  int      mMode    [2] = '{1, 2};
  bit      mBypass  [2] = '{1'b1, 1'b0};
  int      mPerfMax [2] = '{15, 65535};
  int      mPerfLk  [2] = '{0, 0};
  int      mPerfMis [2] = '{0, 0};

  bit cRst, cLv, cUv, cUbr, cUtk, cUmis;
  int cLpc, cUpc, cUtgt;

  function automatic int pcIdx(input int pc);
    return (pc / 2) % 16;
  endfunction

  function automatic int pcTag(input int pc);
    return pc / 32;
  endfunction

  function automatic mEntry_t modelUpdate(input mEntry_t e);
    mEntry_t r;
    bit      h;
    r = e;
    h = e.valid && (e.tag == pcTag(cUpc));
    if (cUbr) begin
      r.target = cUtgt;
      if (h) begin
        r.ctr = cUtk ? ((e.ctr < 3) ? e.ctr + 1 : 3) : ((e.ctr > 0) ? e.ctr - 1 : 0);
      end else begin
        r.valid = 1'b1;
        r.tag   = pcTag(cUpc);
        r.ctr   = cUtk ? 2 : 1;
      end
    end else if (h) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit lv, input int lpc,
                               input bit uv, input int upc, input bit ubr,
                               input bit utk, input int utgt, input bit umis);
    cRst = rst; cLv = lv; cLpc = lpc; cUv = uv; cUpc = upc;
    cUbr = ubr; cUtk = utk; cUtgt = utgt; cUmis = umis;
    reset = rst;
    ifA.lookup_valid = lv;   ifB.lookup_valid = lv;
    ifA.lookup_pc = 16'(lpc); ifB.lookup_pc = 16'(lpc);
    ifA.upd_valid = uv;      ifB.upd_valid = uv;
    ifA.upd_pc = 16'(upc);   ifB.upd_pc = 16'(upc);
    ifA.upd_is_branch = ubr; ifB.upd_is_branch = ubr;
    ifA.upd_taken = utk;     ifB.upd_taken = utk;
    ifA.upd_target = 16'(utgt); ifB.upd_target = 16'(utgt);
    ifA.upd_mispredict = umis;  ifB.upd_mispredict = umis;
  endtask

  task automatic checkOutput(input string label);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mEntry_t     e;
      bit          eHit, eTaken;
      int          eTgt;
      logic        oHit, oTaken;
      logic [31:0] oTgt, oLk, oMis;
      eHit   = 1'b0;
      eTaken = 1'b0;
      eTgt   = (cLpc + 2) % 65536;
      if (cRst) begin
        e = mTab[k][pcIdx(cLpc)];
        if (mBypass[k] && cUv && (pcIdx(cUpc) == pcIdx(cLpc))) begin
          e = modelUpdate(e);
        end
        eHit = cLv && e.valid && (e.tag == pcTag(cLpc));
        if (mMode[k] == 1) eTaken = eHit && (e.ctr >= 2);
        if (mMode[k] == 2) eTaken = eHit;
        if (eTaken) eTgt = e.target;
      end
      oHit   = (k == 0) ? ifA.pred_hit : ifB.pred_hit;
      oTaken = (k == 0) ? ifA.pred_taken : ifB.pred_taken;
      oTgt   = (k == 0) ? 32'(ifA.pred_target) : 32'(ifB.pred_target);
      oLk    = (k == 0) ? 32'(ifA.perf_lookups) : 32'(ifB.perf_lookups);
      oMis   = (k == 0) ? 32'(ifA.perf_mispredicts) : 32'(ifB.perf_mispredicts);
      check($sformatf("%s/dut%0d/hit", label, k), 32'(oHit), 32'(eHit));
      check($sformatf("%s/dut%0d/taken", label, k), 32'(oTaken), 32'(eTaken));
      check($sformatf("%s/dut%0d/target", label, k), oTgt, 32'(eTgt));
      check($sformatf("%s/dut%0d/perf_lookups", label, k), oLk, 32'(mPerfLk[k]));
      check($sformatf("%s/dut%0d/perf_mispredicts", label, k), oMis, 32'(mPerfMis[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!cRst) begin
        for (int i = 0; i < 16; i++) begin
          mTab[k][i].valid = 1'b0;
          mTab[k][i].ctr   = 1;
        end
        mPerfLk[k]  = 0;
        mPerfMis[k] = 0;
      end else begin
        if (cUv) mTab[k][pcIdx(cUpc)] = modelUpdate(mTab[k][pcIdx(cUpc)]);
        if (cLv && (mPerfLk[k] < mPerfMax[k])) mPerfLk[k]++;
        if (cUv && cUmis && (mPerfMis[k] < mPerfMax[k])) mPerfMis[k]++;
      end
    end
    #1;
  endtask

  task automatic step(input string label, input bit rst, input bit lv, input int lpc,
                      input bit uv, input int upc, input bit ubr, input bit utk,
                      input int utgt, input bit umis);
    applyStimulus(rst, lv, lpc, uv, upc, ubr, utk, utgt, umis);
    checkOutput(label);
    tick();
  endtask

  // Directed scenarios followed by randomized traffic, then the summary.
  initial begin
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    tick();
    step("inReset", 1'b0, 1'b1, 'h0040, 1'b1, 'h0040, 1'b1, 1'b1, 'h0100, 1'b0);

    step("coldLookup", 1'b1, 1'b1, 'h0040, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step("wrapTarget", 1'b1, 1'b1, 'hFFFE, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    step("alloc40", 1'b1, 1'b0, 'h0040, 1'b1, 'h0040, 1'b1, 1'b1, 'h0100, 1'b0);
    step("hit40", 1'b1, 1'b1, 'h0040, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step("nt40a", 1'b1, 1'b1, 'h0040, 1'b1, 'h0040, 1'b1, 1'b0, 'h0100, 1'b1);
    step("nt40b", 1'b1, 1'b1, 'h0040, 1'b1, 'h0040, 1'b1, 1'b0, 'h0100, 1'b1);
    step("weak40", 1'b1, 1'b1, 'h0040, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step($sformatf("tk10_%0d", i), 1'b1, 1'b1, 'h0010, 1'b1, 'h0010, 1'b1, 1'b1, 'h0400, 1'b0);
    end
    step("nt10", 1'b1, 1'b1, 'h0010, 1'b1, 'h0010, 1'b1, 1'b0, 'h0400, 1'b0);
    step("sat10", 1'b1, 1'b1, 'h0010, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    step("alloc20", 1'b1, 1'b0, 0, 1'b1, 'h0020, 1'b1, 1'b1, 'h0300, 1'b0);
    step("alias40", 1'b1, 1'b1, 'h0040, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step("kill20", 1'b1, 1'b0, 0, 1'b1, 'h0020, 1'b0, 1'b0, 0, 1'b0);
    step("gone20", 1'b1, 1'b1, 'h0020, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    step("bypass60", 1'b1, 1'b1, 'h0060, 1'b1, 'h0060, 1'b1, 1'b1, 'h0200, 1'b0);
    step("after60", 1'b1, 1'b1, 'h0060, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      step($sformatf("misp_%0d", i), 1'b1, 1'b1, 'h0080, 1'b1, 'h0090, 1'b0, 1'b0, 0, 1'b1);
    end
    step("midReset0", 1'b0, 1'b1, 'h0060, 1'b1, 'h0060, 1'b1, 1'b1, 'h0500, 1'b1);
    step("midReset1", 1'b0, 1'b1, 'h0010, 1'b1, 'h0090, 1'b0, 1'b0, 0, 1'b1);
    step("postReset", 1'b1, 1'b1, 'h0060, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step("postReset10", 1'b1, 1'b1, 'h0010, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int lpc, upc;
      lpc = int'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
      upc = int'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) lpc = int'(16'hFFFE | $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) upc = 'hFFFE;
      step($sformatf("rand_%0d", i), ($urandom_range(0, 49) != 0), 1'($urandom), lpc,
           1'($urandom), upc, ($urandom_range(0, 3) != 0), 1'($urandom),
           int'($urandom & 32'hFFFF), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
